// File: rtl/wb_cmd_master.sv
// wb_cmd_master: single-outstanding Wishbone classic-cycle initiator.
// A client hands over one read/write command on a valid/ready port. The block
// runs it on the bus and returns read data plus err/timeout status on a
// valid/ready response port. A watchdog aborts cycles that a dead slave never
// terminates.
module wb_cmd_master #(
  parameter int unsigned TIMEOUT = 255,  // bus cycles before abort; 0 disables
  parameter int unsigned TO_W    = 8     // counter width, must hold TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  // command port
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  // response port
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        rsp_timeout,
  // Wishbone initiator
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Counter value seen on the last permitted bus cycle. Only used when the
  // watchdog is enabled, so the TIMEOUT==0 case just needs a legal constant.
  localparam int unsigned      TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LAST_I);
  localparam bit               TO_EN     = (TIMEOUT != 0);

  state_t          state;
  logic [TO_W-1:0] to_cnt;

  // Command/bus/response sequencer. Every output is a register, so the async
  // reset drops cyc/stb immediately without waiting for a clock edge.
  // NOTE: state is written with non-blocking assignments only, so every
  // branch below reads the values from before this edge, not half-updated ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      to_cnt      <= '0;
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_dat     <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wb_cyc_o    <= 1'b0;
      wb_stb_o    <= 1'b0;
      wb_we_o     <= 1'b0;
      wb_adr_o    <= '0;
      wb_sel_o    <= '0;
      wb_dat_o    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            // The wb_* registers double as the latched command; they are only
            // loaded here, so they stay stable for the whole bus cycle.
            wb_we_o   <= cmd_we;
            wb_adr_o  <= cmd_adr;
            wb_dat_o  <= cmd_dat;
            wb_sel_o  <= cmd_sel;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= 1'b1;
            cmd_ready <= 1'b0;
            to_cnt    <= '0;
            state     <= BUS;
          end
        end

        BUS: begin
          to_cnt <= to_cnt + 1'b1;
          // Priority: err over ack, and either over the watchdog on its last cycle.
          if (wb_err_i) begin
            rsp_dat     <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            state       <= RESP;
          end else if (wb_ack_i) begin
            rsp_dat     <= wb_we_o ? 32'h0 : wb_dat_i;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            state       <= RESP;
          end else if (TO_EN && (to_cnt == TO_LAST)) begin
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            state       <= RESP;
          end
        end

        RESP: begin
          // Response holds until consumed; bus inputs are ignored here.
          if (rsp_ready) begin
            rsp_valid   <= 1'b0;
            rsp_dat     <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            to_cnt      <= '0;
            cmd_ready   <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          wb_cyc_o  <= 1'b0;
          wb_stb_o  <= 1'b0;
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          to_cnt    <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Single-outstanding Wishbone classic-cycle initiator for the LM32 SoC fabric.
- Accepts one command at a time from a local client on a valid/ready port, such as a debug UART bridge or the LCD/menu sequencer.
- Runs the read or write on the bus, against slaves like the LCD or GPIO peripherals, and returns read data plus status on a valid/ready response port.
- Includes a bus-timeout watchdog so a dead slave cannot hang the client.

Parameters:
- TIMEOUT, 255: cycles to wait for ack/err after cyc/stb assert before aborting. 0 disables the watchdog.
- TO_W, 8: width of the timeout counter. Must hold TIMEOUT.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  client command present.
- cmd_ready  out  1  block can accept a command.
- cmd_we  in  1  1=write, 0=read.
- cmd_adr  in  32  byte address.
- cmd_dat  in  32  write data.
- cmd_sel  in  4  byte lane selects.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  client consumes response.
- rsp_dat  out  32  read data; 0 for writes and errors.
- rsp_err  out  1  slave returned err.
- rsp_timeout  out  1  watchdog expired.
- wb_cyc_o  out  1  Wishbone cycle.
- wb_stb_o  out  1  Wishbone strobe.
- wb_we_o  out  1  write enable.
- wb_adr_o  out  32  address.
- wb_sel_o  out  4  byte selects.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  slave acknowledge.
- wb_err_i  in  1  slave error.

Behaviour:
- Reset is asynchronous and active-high; the clock is clk and the reset is reset.
- Reset values:
  - State IDLE.
  - All outputs 0, except cmd_ready=1.
  - Timeout counter 0.
- State IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch we/adr/dat/sel into internal registers and go to BUS.
  - Without cmd_valid, stay in IDLE.
- State BUS:
  - wb_cyc_o=wb_stb_o=1; wb_we_o/adr_o/sel_o/dat_o come from the latched registers and stay stable for the whole state.
  - cmd_ready=0.
  - The counter increments each BUS cycle.
  - If wb_ack_i is sampled: capture wb_dat_i into rsp_dat when it is a read (0 when a write); rsp_err=0, rsp_timeout=0; go to RESP.
  - If wb_err_i is sampled: rsp_dat=0, rsp_err=1; go to RESP.
  - If ack and err are sampled in the same cycle, err wins.
  - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack/err: rsp_timeout=1, rsp_dat=0; go to RESP.
  - If ack/err arrives on that same final cycle, ack/err wins over timeout.
- State RESP:
  - cyc/stb=0 from the first RESP cycle. A registered slave that gates ack with stb therefore sees stb drop the cycle after its ack, and there is no double transfer.
  - rsp_valid=1; rsp_dat/err/timeout hold stable until rsp_valid & rsp_ready.
  - Then rsp_valid=0, flags cleared, counter cleared; go to IDLE.
  - cmd_ready=0 while in RESP. No new command is accepted until the response is consumed, so at most one command is outstanding.
- Latency:
  - Command accepted at edge N; cyc/stb high from N+1.
  - Against a slave with registered one-cycle ack (ack sampled at edge N+2): rsp_valid high from N+2 → response at N+2/N+3.
  - Minimum command-to-command spacing is 3 cycles.
- wb_adr_o is passed through unmodified; byte-address decoding is the slave's job.
- Reset mid-cycle: cyc/stb drop immediately (asynchronously); a pending response is discarded, with no rsp_valid afterwards.
- An ack/err/dat seen in IDLE or RESP is ignored.

Test Plan:
- Write:
  - Stimulus: cmd we=1, adr=0x20000014, dat=0xA5A5_0001, sel=0xF; slave acks 1 cycle after stb.
  - Required: bus shows those values with cyc/stb high exactly 2 cycles; rsp_valid with err=0, timeout=0, dat=0.
- Read:
  - Stimulus: cmd we=0, adr=0x20000000; slave returns 0x0000_0000 (LCD control register), then a second read returns 0xDEAD_BEEF from another slave.
  - Required: rsp_dat matches each value; cmd_ready is low from accept until rsp handshake.
- Response backpressure:
  - Stimulus: rsp_ready held 0 for 10 cycles after a read.
  - Required: rsp_valid/rsp_dat stable all 10 cycles; cyc/stb low; a cmd_valid presented meanwhile is not accepted until 1 cycle after the rsp handshake.
- Timeout (TIMEOUT=16):
  - Stimulus: slave never acks.
  - Required: cyc/stb high exactly 16 cycles; rsp_timeout=1, rsp_dat=0.
  - Repeat with ack on the 16th cycle; required: normal completion, rsp_timeout=0.
- Error:
  - Stimulus: slave asserts err; in a separate cycle, asserts ack and err together.
  - Required: rsp_err=1 both times, rsp_dat=0.
- Reset:
  - Stimulus: assert reset mid-BUS, between clock edges.
  - Required: cyc/stb fall before the next edge; after release, cmd_ready=1, rsp_valid=0, and a new write completes normally.
